// File: rtl/branch_predictor_if.sv
// Fetch/execute side bundle for the branch predictor: lookup request,
// registered prediction, and resolved-branch training.
interface branch_predictor_if;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        flush;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output lk_valid, lk_pc, flush, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_valid, pred_pc, pred_taken, pred_target
  );

  modport slave (
    input  lk_valid, lk_pc, flush, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_valid, pred_pc, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// One-cycle registered lookup, read-before-write against same-cycle training.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic        pred_valid_q, pred_valid_d;
  logic [31:0] pred_pc_q, pred_pc_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;

  logic [INDEX_BITS-1:0] lk_idx, upd_idx;
  logic [TAG_BITS-1:0]   lk_tag, upd_tag;
  logic                  lk_hit, upd_hit;

  logic       ctr_wr, tgt_wr, tag_wr;
  logic [1:0] ctr_d;

  // Low two bits and bits above the tag field of the update PC carry no table information.
  logic unused_upd_bits;
  assign unused_upd_bits = ^{bus.upd_pc[31:TAG_HI+1], bus.upd_pc[1:0]};

  assign lk_idx  = bus.lk_pc[INDEX_BITS+1:2];
  assign lk_tag  = bus.lk_pc[TAG_HI:TAG_LO];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign upd_idx = bus.upd_pc[INDEX_BITS+1:2];
  assign upd_tag = bus.upd_pc[TAG_HI:TAG_LO];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    pred_valid_d  = 1'b0;
    pred_pc_d     = pred_pc_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (bus.lk_valid && !bus.flush) begin
      pred_valid_d = 1'b1;
      pred_pc_d    = bus.lk_pc;
      if (lk_hit && ctr_q[lk_idx][1]) begin
        pred_taken_d  = 1'b1;
        pred_target_d = target_q[lk_idx];
      end else begin
        pred_taken_d  = 1'b0;
        pred_target_d = bus.lk_pc + 32'd4;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    ctr_wr  = 1'b0;
    tgt_wr  = 1'b0;
    tag_wr  = 1'b0;
    ctr_d   = 2'b10;
    if (bus.upd_valid) begin
      if (upd_hit) begin
        ctr_wr = 1'b1;
        tgt_wr = bus.upd_taken;
        ctr_d  = bus.upd_taken ? sat_inc(ctr_q[upd_idx]) : sat_dec(ctr_q[upd_idx]);
      end else if (bus.upd_taken) begin
        // Only taken branches allocate; new entries start weakly taken.
        valid_d[upd_idx] = 1'b1;
        tag_wr           = 1'b1;
        tgt_wr           = 1'b1;
        ctr_wr           = 1'b1;
        ctr_d            = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      pred_valid_q  <= 1'b0;
      pred_pc_q     <= 32'd0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'd0;
    end else begin
      valid_q       <= valid_d;
      pred_valid_q  <= pred_valid_d;
      pred_pc_q     <= pred_pc_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (tag_wr) tag_q[upd_idx]    <= upd_tag;
    if (tgt_wr) target_q[upd_idx] <= bus.upd_target;
    if (ctr_wr) ctr_q[upd_idx]    <= ctr_d;
  end

  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_pc     = pred_pc_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.pred_target = pred_target_q;
endmodule
